pc_seq: RTL and testbench

Parametrised program-counter sequencer for the micro-MIPS fetch stage. After reset it accepts a vector table of addresses through a valid/ready load port, boots from entry 0, and then produces one registered fetch address per enabled cycle. Supported operations are sequential increment, direct branch, table-indexed jump and, optionally, call/return through a hardware return-address stack. It replaces the fixed 256×32 PC table with configurable width and depth, a load handshake, bounds checking and a fault state.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_ras.sv | 49 ++++
 rtl/pc_seq.sv | 174 +++++++++++++++++
 tb/tb_pc_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the pc_seq fetch sequencer:
// operation codes and controller states.
package pc_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SEQ  = 3'd0,
        OP_BR   = 3'd1,
        OP_TBL  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address LIFO for pc_seq; pop_data always shows the top entry.
// Push on full and pop on empty are ignored; the caller flags those.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(RAS_DEPTH + 1);
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [IW-1:0]     w_wr_idx;
    logic [IW-1:0]     w_rd_idx;
    logic [PW-1:0]     w_ptr_m1;

    assign w_ptr_m1 = r_ptr - 1'b1;
    assign w_wr_idx = IW'(r_ptr);
    assign w_rd_idx = IW'(w_ptr_m1);
    assign full     = (r_ptr == PW'(RAS_DEPTH));
    assign empty    = (r_ptr == '0);
    assign pop_data = r_mem[w_rd_idx];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_ptr <= '0;
        end else if (push && !full) begin
            r_ptr <= r_ptr + 1'b1;
        end else if (pop && !empty) begin
            r_ptr <= w_ptr_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: table load, boot from entry 0, then SEQ/BR/TBL/CALL/RET.
// Define PC_SEQ_RAS_EN to build the return-address stack for CALL/RET.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int TBL_DEPTH = 256,
    parameter int INC       = 4,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_data,
    input  logic                         ld_last,
    output logic                         ld_ready,
    input  logic                         en,
    input  logic [OP_W-1:0]              op,
    input  logic [ADDR_W-1:0]            target,
    input  logic [$clog2(TBL_DEPTH)-1:0] tbl_idx,
    output logic [ADDR_W-1:0]            out,
    output logic                         out_valid,
    output logic                         err
);

    localparam int IDX_W = $clog2(TBL_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    if (TBL_DEPTH < 2 || (TBL_DEPTH & (TBL_DEPTH - 1)) != 0
        || RAS_DEPTH < 1) begin : g_bad_cfg
        $error("pc_seq: illegal TBL_DEPTH or RAS_DEPTH");
    end

    state_e            r_st;
    state_e            w_st_nxt;
    logic [ADDR_W-1:0] r_tbl [TBL_DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_out;
    logic [ADDR_W-1:0] w_out_nxt;
    logic [ADDR_W-1:0] w_inc;
    logic              r_vld;
    logic              w_vld_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_wr;
    logic              w_fault;

`ifdef PC_SEQ_RAS_EN
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_pop_data;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .res       (res),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_inc),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty)
    );
`endif

    assign w_inc     = r_out + ADDR_W'(INC);
    assign ld_ready  = (r_st == ST_LOAD);
    assign out       = r_out;
    assign out_valid = r_vld;
    assign err       = r_err;

    always_comb begin
        w_st_nxt  = r_st;
        w_cnt_nxt = r_cnt;
        w_out_nxt = r_out;
        w_vld_nxt = r_vld;
        w_err_nxt = r_err;
        w_wr      = 1'b0;
        w_fault   = 1'b0;
`ifdef PC_SEQ_RAS_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        case (r_st)
            ST_LOAD: begin
                if (ld_valid) begin
                    w_wr      = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (ld_last || r_cnt == CNT_W'(TBL_DEPTH - 1)) begin
                        w_st_nxt = ST_BOOT;
                    end
                end
            end
            ST_BOOT: begin
                w_out_nxt = r_tbl[0];
                w_vld_nxt = 1'b1;
                w_st_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (en) begin
                    case (op)
                        OP_SEQ: w_out_nxt = w_inc;
                        OP_BR:  w_out_nxt = target;
                        OP_TBL: begin
                            if ({1'b0, tbl_idx} < r_cnt) begin
                                w_out_nxt = r_tbl[tbl_idx];
                            end else begin
                                w_fault = 1'b1;
                            end
                        end
`ifdef PC_SEQ_RAS_EN
                        OP_CALL: begin
                            if (w_full) begin
                                w_fault = 1'b1;
                            end else begin
                                w_push    = 1'b1;
                                w_out_nxt = target;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_fault = 1'b1;
                            end else begin
                                w_pop     = 1'b1;
                                w_out_nxt = w_pop_data;
                            end
                        end
`else
                        // Without a stack a call is a plain branch.
                        OP_CALL: w_out_nxt = target;
`endif
                        default: w_fault = 1'b1;
                    endcase
                end
            end
            default: begin
            end
        endcase
        if (w_fault) begin
            w_st_nxt  = ST_FAULT;
            w_err_nxt = 1'b1;
            w_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_st  <= ST_LOAD;
            r_cnt <= '0;
            r_out <= '0;
            r_vld <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
            r_out <= w_out_nxt;
            r_vld <= w_vld_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Table survives reset; r_cnt gates what is visible.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_tbl[r_cnt[IDX_W-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: vector table for the RUN ops
// plus hand sequences for load/boot, reset, RAS and full-table load.
module tb_pc_seq;
    import pc_seq_pkg::*;

    logic        clk;
    logic        res;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        en;
    logic [2:0]  op;
    logic [31:0] target;
    logic [1:0]  tbl_idx;
    logic [31:0] out;
    logic        out_valid;
    logic        err;

    int n_pass = 0;
    int n_tot  = 0;

    pc_seq #(
        .ADDR_W    (32),
        .TBL_DEPTH (4),
        .INC       (4),
        .RAS_DEPTH (2)
    ) dut (
        .clk       (clk),
        .res       (res),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .en        (en),
        .op        (op),
        .target    (target),
        .tbl_idx   (tbl_idx),
        .out       (out),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [31:0] tgt;
        logic [1:0]  idx;
        logic [31:0] eo;
        logic        ev;
        logic        ee;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en       = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        res      = 1'b1;
        step();
        res = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] t,
                       input logic [1:0] i);
        en      = 1'b1;
        op      = o;
        target  = t;
        tbl_idx = i;
        step();
        en = 1'b0;
    endtask

    task automatic load3();
        beat(32'h100, 1'b0);
        beat(32'h200, 1'b0);
        beat(32'h300, 1'b1);
        step();
    endtask

    task automatic chk_run(input string nm, input logic [31:0] eo,
                           input logic ev, input logic ee);
        chk({nm, " out"}, out, eo);
        chk({nm, " vld"}, 32'(out_valid), 32'(ev));
        chk({nm, " err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        vt[0]  = '{1'b1, OP_SEQ, 32'h0, 2'd0, 32'h104, 1'b1, 1'b0};
        vt[1]  = '{1'b1, OP_SEQ, 32'h0, 2'd0, 32'h108, 1'b1, 1'b0};
        vt[2]  = '{1'b0, OP_SEQ, 32'h0, 2'd0, 32'h108, 1'b1, 1'b0};
        vt[3]  = '{1'b0, OP_BR, 32'h999, 2'd0, 32'h108, 1'b1, 1'b0};
        vt[4]  = '{1'b0, OP_SEQ, 32'h0, 2'd0, 32'h108, 1'b1, 1'b0};
        vt[5]  = '{1'b1, OP_BR, 32'hFFFF_FFFC, 2'd0,
                   32'hFFFF_FFFC, 1'b1, 1'b0};
        vt[6]  = '{1'b1, OP_SEQ, 32'h0, 2'd0, 32'h0, 1'b1, 1'b0};
        vt[7]  = '{1'b1, OP_TBL, 32'h0, 2'd0, 32'h100, 1'b1, 1'b0};
        vt[8]  = '{1'b1, OP_TBL, 32'h0, 2'd2, 32'h300, 1'b1, 1'b0};
        vt[9]  = '{1'b1, OP_TBL, 32'h0, 2'd3, 32'h300, 1'b0, 1'b1};
        vt[10] = '{1'b1, OP_SEQ, 32'h0, 2'd0, 32'h300, 1'b0, 1'b1};
        vt[11] = '{1'b1, OP_BR, 32'h40, 2'd0, 32'h300, 1'b0, 1'b1};

        res      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        en       = 1'b0;
        op       = '0;
        target   = '0;
        tbl_idx  = '0;
        #1;
        chk_run("rst", 32'h0, 1'b0, 1'b0);
        chk("rst rdy", 32'(ld_ready), 32'd1);
        step();
        res = 1'b0;

        // load/boot latency
        beat(32'h100, 1'b0);
        chk("beat1 rdy", 32'(ld_ready), 32'd1);
        beat(32'h200, 1'b0);
        beat(32'h300, 1'b1);
        chk("boot rdy", 32'(ld_ready), 32'd0);
        chk("boot vld", 32'(out_valid), 32'd0);
        step();
        chk_run("boot", 32'h100, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            en      = vt[i].en;
            op      = vt[i].op;
            target  = vt[i].tgt;
            tbl_idx = vt[i].idx;
            step();
            chk_run($sformatf("vec%0d", i), vt[i].eo, vt[i].ev, vt[i].ee);
        end
        en = 1'b0;
        chk("fault rdy", 32'(ld_ready), 32'd0);

        // reset mid-load, then a 1-beat load
        do_reset();
        beat(32'h111, 1'b0);
        res = 1'b1;
        #1;
        chk_run("midrst", 32'h0, 1'b0, 1'b0);
        chk("midrst rdy", 32'(ld_ready), 32'd1);
        step();
        res = 1'b0;
        beat(32'h700, 1'b1);
        chk("one rdy", 32'(ld_ready), 32'd0);
        step();
        chk_run("one boot", 32'h700, 1'b1, 1'b0);
        run(OP_TBL, 32'h0, 2'd1);
        chk_run("one tbl1", 32'h700, 1'b0, 1'b1);

        // call/return
        do_reset();
        load3();
`ifdef PC_SEQ_RAS_EN
        run(OP_CALL, 32'h500, 2'd0);
        chk_run("call1", 32'h500, 1'b1, 1'b0);
        run(OP_CALL, 32'h600, 2'd0);
        chk_run("call2", 32'h600, 1'b1, 1'b0);
        run(OP_RET, 32'h0, 2'd0);
        chk_run("ret1", 32'h504, 1'b1, 1'b0);
        run(OP_RET, 32'h0, 2'd0);
        chk_run("ret2", 32'h104, 1'b1, 1'b0);
        run(OP_RET, 32'h0, 2'd0);
        chk_run("undflow", 32'h104, 1'b0, 1'b1);
        do_reset();
        load3();
        run(OP_CALL, 32'h500, 2'd0);
        run(OP_CALL, 32'h600, 2'd0);
        run(OP_CALL, 32'h700, 2'd0);
        chk_run("ovflow", 32'h600, 1'b0, 1'b1);
`else
        run(OP_CALL, 32'h500, 2'd0);
        chk_run("call br", 32'h500, 1'b1, 1'b0);
        run(OP_RET, 32'h0, 2'd0);
        chk_run("ret ill", 32'h500, 1'b0, 1'b1);
`endif

        // full table without ld_last, then an illegal op
        do_reset();
        beat(32'hA0, 1'b0);
        beat(32'hB0, 1'b0);
        beat(32'hC0, 1'b0);
        chk("full rdy3", 32'(ld_ready), 32'd1);
        beat(32'hD0, 1'b0);
        chk("full rdy4", 32'(ld_ready), 32'd0);
        step();
        chk_run("full boot", 32'hA0, 1'b1, 1'b0);
        run(OP_TBL, 32'h0, 2'd3);
        chk_run("full tbl3", 32'hD0, 1'b1, 1'b0);
        run(3'd5, 32'h0, 2'd0);
        chk_run("op5", 32'hD0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
